// File: rtl/booth_mult_scheduler.sv
// booth_mult_scheduler: operand FIFO, single-job issue FSM and result register around a sequential Booth multiplier
module booth_mult_scheduler #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             mul_load,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic             mul_done,
  input  logic [2*N-1:0]   mul_c
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state, state_nx;
  logic [N-1:0] fa [DEPTH];
  logic [N-1:0] fb [DEPTH];
  logic [TAG_W-1:0] ft [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic [TAG_W-1:0] tag_cnt, job_tag;
  logic push, pop, done_ok;
  assign push = in_valid && in_ready;
  assign pop = state == S_IDLE && cnt != '0 && !out_valid;
  assign done_ok = state == S_WAIT && mul_done;
  assign cnt_nx = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign busy = cnt != '0 || state != S_IDLE || out_valid;
  always_comb begin
    state_nx = pop ? S_ISSUE : state == S_ISSUE ? S_WAIT : done_ok ? S_IDLE : state;
    mul_load = state == S_ISSUE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      tag_cnt <= '0;
      in_ready <= 1'b1;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt_nx;
      tag_cnt <= push ? tag_cnt + 1'b1 : tag_cnt;
      in_ready <= cnt_nx != (AW+1)'(DEPTH);
    end
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= in_a;
      fb[wp] <= in_b;
      ft[wp] <= tag_cnt;
    end
  // operands stay put from pop through the whole wait, the multiplier samples late
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      job_tag <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
    end else begin
      mul_a <= pop ? fa[rp] : mul_a;
      mul_b <= pop ? fb[rp] : mul_b;
      job_tag <= pop ? ft[rp] : job_tag;
      out_valid <= done_ok ? 1'b1 : (out_valid && out_ready) ? 1'b0 : out_valid;
      out_data <= done_ok ? mul_c : out_data;
      out_tag <= done_ok ? job_tag : out_tag;
    end
endmodule

// File: tb/tb_booth_mult_scheduler.sv
// tb_booth_mult_scheduler: directed checks of the scheduler driving a cycle-level multiplier model
module tb_booth_mult_scheduler;
  localparam int N = 8;
  localparam int TAG_W = 4;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy, mul_load, mul_done;
  logic [N-1:0] in_a = 0, in_b = 0, mul_a, mul_b;
  logic [2*N-1:0] out_data, mul_c;
  logic [TAG_W-1:0] out_tag;
  int checks = 0, errors = 0, loads = 0;

  booth_mult_scheduler #(.N(N), .DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_c(mul_c));

  always #5 clk = ~clk;

  // multiplier stand-in: samples A/B the cycle after load, pulses done several cycles later
  logic m_samp, m_run;
  logic [3:0] m_cnt;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_samp <= 0; m_run <= 0; m_cnt <= 0; mul_done <= 0; mul_c <= 0;
    end else begin
      mul_done <= 0;
      m_samp <= mul_load;
      if (m_samp) begin
        mul_c <= $signed({{N{mul_a[N-1]}}, mul_a}) * $signed({{N{mul_b[N-1]}}, mul_b});
        m_run <= 1; m_cnt <= 5;
      end else if (m_run) begin
        if (m_cnt == 0) begin mul_done <= 1; m_run <= 0; end
        else m_cnt <= m_cnt - 1;
      end
    end

  always @(posedge clk) if (mul_load) loads <= loads + 1;

  task automatic step(); @(negedge clk); endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1; in_a = a; in_b = b;
    while (!in_ready && n < 300) begin step(); n++; end
    if (n >= 300) chk("push_timeout", 0, 1);
    step();
    in_valid = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 300) begin step(); n++; end
    if (n >= 300) chk("result_timeout", 0, 1);
  endtask

  task automatic get_result(input string name, input logic [15:0] d, input logic [3:0] t);
    wait_valid();
    chk({name, "_data"}, 32'(out_data), 32'(d));
    chk({name, "_tag"}, 32'(out_tag), 32'(t));
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  logic [15:0] d0;
  logic [3:0] t0;
  int l0, changes;

  initial begin
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_mul_load", 32'(mul_load), 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;
    step();
    // 1: single job, load two cycles after push, result held until taken
    in_valid = 1; in_a = 8'd3; in_b = 8'hFE;
    step();
    in_valid = 0;
    chk("t1_load_c1", 32'(mul_load), 0);
    chk("t1_busy", 32'(busy), 1);
    step();
    chk("t1_load_c2", 32'(mul_load), 1);
    chk("t1_mul_ab", {mul_a, mul_b}, 32'h03FE);
    step();
    chk("t1_load_c3", 32'(mul_load), 0);
    wait_valid();
    repeat (4) step();
    chk("t1_hold_valid", 32'(out_valid), 1);
    get_result("t1", 16'hFFFA, 4'd0);
    chk("t1_valid_clear", 32'(out_valid), 0);
    chk("t1_idle", 32'(busy), 0);
    // 2/3: fill the FIFO behind a stalled result, then drain in order
    push(8'd1, 8'd1);
    push(8'd2, 8'd3);
    push(8'hFF, 8'd1);
    push(8'd10, 8'hF6);
    push(8'd7, 8'd8);
    chk("t2_full", 32'(in_ready), 0);
    l0 = loads;
    wait_valid();
    d0 = out_data; t0 = out_tag; changes = 0;
    repeat (30) begin
      step();
      if (out_data !== d0 || out_tag !== t0 || !out_valid) changes++;
    end
    chk("t3_no_load", 32'(loads - l0), 0);
    chk("t3_stable", 32'(changes), 0);
    chk("t3_still_full", 32'(in_ready), 0);
    fork
      push(8'hFD, 8'hFB);
      begin
        get_result("t2_r1", 16'h0001, 4'd1);
        get_result("t2_r2", 16'h0006, 4'd2);
        get_result("t2_r3", 16'hFFFF, 4'd3);
        get_result("t2_r4", 16'hFF9C, 4'd4);
        get_result("t2_r5", 16'h0038, 4'd5);
        get_result("t2_r6", 16'h000F, 4'd6);
      end
    join
    // 4: signed corners
    push(8'h80, 8'h80); get_result("t4_mm", 16'h4000, 4'd7);
    push(8'h80, 8'h7F); get_result("t4_mp", 16'hC080, 4'd8);
    push(8'h00, 8'h5A); get_result("t4_zero", 16'h0000, 4'd9);
    push(8'h7F, 8'h7F); get_result("t4_pp", 16'h3F01, 4'd10);
    // 5: tag wrap across 20 jobs
    fork
      for (int i = 0; i < 20; i++) push(8'(i), 8'd3);
      for (int j = 0; j < 20; j++) get_result("t5", 16'(3 * j), 4'((11 + j) % 16));
    join
    // 6: reset while waiting on the multiplier
    push(8'd9, 8'd9);
    begin
      int n = 0;
      while (!mul_load && n < 50) begin step(); n++; end
    end
    step(); step();
    rst = 1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_out_data", 32'(out_data), 0);
    chk("t6_out_tag", 32'(out_tag), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_mul_ab", {mul_a, mul_b}, 0);
    step();
    rst = 0;
    changes = 0;
    repeat (30) begin step(); if (out_valid) changes++; end
    chk("t6_no_stale", 32'(changes), 0);
    push(8'd5, 8'd6);
    get_result("t6_new", 16'h001E, 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
